// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the 16-bit core.
// It fetches instructions over a single-port memory handshake and holds
// them on INSTR. It times the execute phase, including the multi-cycle
// multiply. It also runs load/store accesses, register writeback and the
// CARRY update, and owns the PC.
// Every output is driven straight from a flop. Each output flop is loaded
// from the next-state decode, so it changes on the same edge as the state
// register and no input reaches an output combinationally.
// Ports:
//   CLK, nRESET           clock (rising edge), async active-low reset
//   MEM_ADDR/RD/WR        memory request (PC in FETCH, latched address in MEM)
//   MEM_READY, MEM_RDATA  memory acknowledge and read data
//   ALU_ADDR, ALU_COUT    effective address and carry-out, last EXEC cycle
//   INSTR                 instruction register
//   CARRY                 carry flag
//   REG_WE/REG_WSEL/WB_SEL register-file writeback control
//   LD_DATA               load data register
//   HALTED                high in the HALT state
module instr_sequencer #(
  parameter int                   PC_WIDTH   = 16,
  parameter int                   MUL_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = {PC_WIDTH{1'b0}}
) (
  input  logic                CLK,
  input  logic                nRESET,
  output logic [PC_WIDTH-1:0] MEM_ADDR,
  output logic                MEM_RD,
  output logic                MEM_WR,
  input  logic                MEM_READY,
  input  logic [15:0]         MEM_RDATA,
  input  logic [15:0]         ALU_ADDR,
  input  logic                ALU_COUT,
  output logic [15:0]         INSTR,
  output logic                CARRY,
  output logic                REG_WE,
  output logic [1:0]          REG_WSEL,
  output logic                WB_SEL,
  output logic [15:0]         LD_DATA,
  output logic                HALTED
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic op_is_alu(input logic [4:0] op);
    return ((op >= 5'b00001) && (op <= 5'b01011)) || (op[4:1] == 4'b0110);
  endfunction

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == 5'b00111) || (op == 5'b01000);
  endfunction

  state_t              state_r, state_n;
  logic [PC_WIDTH-1:0] pc_r, pc_n;
  logic [PC_WIDTH-1:0] addr_r, addr_n;
  logic [PC_WIDTH-1:0] mem_addr_r, mem_addr_n;
  logic [15:0]         instr_r, instr_n;
  logic [15:0]         ld_data_r, ld_data_n;
  logic [3:0]          cnt_r, cnt_n;
  logic                carry_r, carry_n;
  logic                carry_stage_r, carry_stage_n;
  logic                mem_rd_r, mem_rd_n;
  logic                mem_wr_r, mem_wr_n;
  logic                reg_we_r, reg_we_n;
  logic                wb_sel_r, wb_sel_n;
  logic                halted_r, halted_n;

  logic [4:0] op_s;
  logic       is_alu_s, is_mul_s, is_ldr_s, is_sti_s, is_halt_s, is_nop_s;

  // Opcode classification of the latched instruction.
  always_comb begin
    op_s      = instr_r[15:11];
    is_alu_s  = op_is_alu(op_s);
    is_mul_s  = op_is_mul(op_s);
    is_ldr_s  = (op_s == 5'b11000);
    is_sti_s  = (op_s == 5'b11001);
    is_halt_s = (op_s == 5'b11111);
    is_nop_s  = !(is_alu_s || is_ldr_s || is_sti_s || is_halt_s);
  end

  // Next-state, datapath-register and registered-output decode.
  always_comb begin
    state_n       = state_r;
    pc_n          = pc_r;
    addr_n        = addr_r;
    instr_n       = instr_r;
    ld_data_n     = ld_data_r;
    cnt_n         = cnt_r;
    carry_n       = carry_r;
    carry_stage_n = carry_stage_r;

    case (state_r)
      ST_IDLE: begin
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (MEM_READY) begin
          instr_n = MEM_RDATA;
          state_n = ST_DECODE;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_halt_s) begin
          state_n = ST_HALT;
        end else if (is_nop_s) begin
          state_n = ST_WB;
        end else begin
          state_n = ST_EXEC;
          cnt_n   = is_mul_s ? 4'(MUL_CYCLES) : 4'd1;
        end
      end
      ST_EXEC: begin
        cnt_n = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          // ALU_ADDR and ALU_COUT are only valid in the last EXEC cycle.
          addr_n        = ALU_ADDR[PC_WIDTH-1:0];
          carry_stage_n = ALU_COUT;
          state_n       = (is_ldr_s || is_sti_s) ? ST_MEM : ST_WB;
        end else begin
          state_n = ST_EXEC;
        end
      end
      ST_MEM: begin
        if (MEM_READY) begin
          if (is_ldr_s) begin
            ld_data_n = MEM_RDATA;
          end else begin
            ld_data_n = ld_data_r;
          end
          state_n = ST_WB;
        end else begin
          state_n = ST_MEM;
        end
      end
      ST_WB: begin
        if (is_alu_s) begin
          carry_n = carry_stage_r;
        end else begin
          carry_n = carry_r;
        end
        pc_n    = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        state_n = ST_FETCH;
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Outputs are a function of the state being entered. Entering MEM or
    // WB always happens with INSTR already stable, so the opcode decode of
    // instr_r is valid here.
    mem_rd_n   = (state_n == ST_FETCH) || ((state_n == ST_MEM) && is_ldr_s);
    mem_wr_n   = (state_n == ST_MEM) && is_sti_s;
    reg_we_n   = (state_n == ST_WB) && (is_alu_s || is_ldr_s);
    wb_sel_n   = (state_n == ST_WB) && is_ldr_s;
    halted_n   = (state_n == ST_HALT);
    mem_addr_n = (state_n == ST_MEM) ? addr_n : pc_n;
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      addr_r        <= {PC_WIDTH{1'b0}};
      mem_addr_r    <= RESET_PC;
      instr_r       <= 16'h0000;
      ld_data_r     <= 16'h0000;
      cnt_r         <= 4'd0;
      carry_r       <= 1'b0;
      carry_stage_r <= 1'b0;
      mem_rd_r      <= 1'b0;
      mem_wr_r      <= 1'b0;
      reg_we_r      <= 1'b0;
      wb_sel_r      <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_n;
      pc_r          <= pc_n;
      addr_r        <= addr_n;
      mem_addr_r    <= mem_addr_n;
      instr_r       <= instr_n;
      ld_data_r     <= ld_data_n;
      cnt_r         <= cnt_n;
      carry_r       <= carry_n;
      carry_stage_r <= carry_stage_n;
      mem_rd_r      <= mem_rd_n;
      mem_wr_r      <= mem_wr_n;
      reg_we_r      <= reg_we_n;
      wb_sel_r      <= wb_sel_n;
      halted_r      <= halted_n;
    end
  end

  assign MEM_ADDR = mem_addr_r;
  assign MEM_RD   = mem_rd_r;
  assign MEM_WR   = mem_wr_r;
  assign INSTR    = instr_r;
  assign CARRY    = carry_r;
  assign REG_WE   = reg_we_r;
  assign REG_WSEL = instr_r[10:9];
  assign WB_SEL   = wb_sel_r;
  assign LD_DATA  = ld_data_r;
  assign HALTED   = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer.
// The main instance runs with MUL_CYCLES=3 and RESET_PC=0. A second
// instance with RESET_PC=0xFFFF covers PC wrap-around. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_instr_sequencer;

  logic        clk;
  logic        n_reset;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready;
  logic [15:0] mem_rdata, alu_addr;
  logic        alu_cout;
  logic [15:0] instr;
  logic        carry, reg_we, wb_sel, halted;
  logic [1:0]  reg_wsel;
  logic [15:0] ld_data;

  logic        w_n_reset;
  logic [15:0] w_mem_addr;
  logic        w_mem_rd, w_mem_wr, w_mem_ready;
  logic [15:0] w_mem_rdata;
  logic [15:0] w_instr;
  logic        w_carry, w_reg_we, w_wb_sel, w_halted;
  logic [1:0]  w_reg_wsel;
  logic [15:0] w_ld_data;

  int n_checks;
  int n_fail;

  instr_sequencer #(.PC_WIDTH(16), .MUL_CYCLES(3), .RESET_PC(16'h0000)) dut (
    .CLK(clk), .nRESET(n_reset), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd),
    .MEM_WR(mem_wr), .MEM_READY(mem_ready), .MEM_RDATA(mem_rdata),
    .ALU_ADDR(alu_addr), .ALU_COUT(alu_cout), .INSTR(instr), .CARRY(carry),
    .REG_WE(reg_we), .REG_WSEL(reg_wsel), .WB_SEL(wb_sel),
    .LD_DATA(ld_data), .HALTED(halted)
  );

  instr_sequencer #(.PC_WIDTH(16), .MUL_CYCLES(2), .RESET_PC(16'hFFFF)) dut_wrap (
    .CLK(clk), .nRESET(w_n_reset), .MEM_ADDR(w_mem_addr), .MEM_RD(w_mem_rd),
    .MEM_WR(w_mem_wr), .MEM_READY(w_mem_ready), .MEM_RDATA(w_mem_rdata),
    .ALU_ADDR(16'h0000), .ALU_COUT(1'b0), .INSTR(w_instr), .CARRY(w_carry),
    .REG_WE(w_reg_we), .REG_WSEL(w_reg_wsel), .WB_SEL(w_wb_sel),
    .LD_DATA(w_ld_data), .HALTED(w_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    n_checks++;
    if ({mem_rd, mem_wr, reg_we, wb_sel, halted} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_rd, mem_wr, reg_we, wb_sel, halted});
    end
    n_checks++;
    if ({instr, ld_data, carry, mem_addr} !== 49'h0) begin
      n_fail++; $display("FAIL reset_regs: instr=%h ld=%h carry=%b addr=%h expected all zero", instr, ld_data, carry, mem_addr);
    end
    tick();
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_first_fetch: rd=%b addr=%h expected 1 0000", mem_rd, mem_addr);
    end
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if (mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_drop: rd=%b expected 0", mem_rd);
    end
    tick();
    n_reset = 1'b1;
    n_checks++;
    if (mem_rd !== 1'b0 || instr !== 16'h0000 || carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: rd=%b instr=%h carry=%b expected 0 0000 0", mem_rd, instr, carry);
    end
    tick();
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_refetch: rd=%b addr=%h expected 1 0000", mem_rd, mem_addr);
    end
  endtask

  // adr: FETCH, DECODE, EXEC, WB -> REG_WE in the 4th cycle.
  task automatic test_alu();
    mem_rdata = 16'h0A00; mem_ready = 1'b1; alu_cout = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      mem_ready = 1'b0;
      n_checks++;
      if (reg_we !== (c == 4)) begin
        n_fail++; $display("FAIL alu_reg_we_c%0d: got %b expected %b", c, reg_we, (c == 4));
      end
    end
    n_checks++;
    if (reg_wsel !== 2'b01 || wb_sel !== 1'b0 || instr !== 16'h0A00) begin
      n_fail++; $display("FAIL alu_wb: wsel=%b wbsel=%b instr=%h expected 01 0 0a00", reg_wsel, wb_sel, instr);
    end
    tick();
    n_checks++;
    if (carry !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 16'h0001 || reg_we !== 1'b0) begin
      n_fail++; $display("FAIL alu_next_fetch: carry=%b rd=%b addr=%h we=%b expected 1 1 0001 0", carry, mem_rd, mem_addr, reg_we);
    end
  endtask

  // mlr with MUL_CYCLES=3: EXEC in cycles 3..5, WB in cycle 6.
  task automatic test_mul();
    mem_rdata = 16'h3800; mem_ready = 1'b1; alu_cout = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      tick();
      mem_ready = 1'b0;
      alu_cout  = (c == 5) ? 1'b0 : 1'b1;
      n_checks++;
      if (reg_we !== (c == 6)) begin
        n_fail++; $display("FAIL mul_reg_we_c%0d: got %b expected %b", c, reg_we, (c == 6));
      end
    end
    n_checks++;
    if (reg_wsel !== 2'b00) begin
      n_fail++; $display("FAIL mul_wsel: got %b expected 00", reg_wsel);
    end
    tick();
    n_checks++;
    if (carry !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0002) begin
      n_fail++; $display("FAIL mul_next_fetch: carry=%b rd=%b addr=%h expected 0 1 0002", carry, mem_rd, mem_addr);
    end
  endtask

  // ldr with two wait cycles in MEM: MEM in cycles 4..6, WB in cycle 7.
  task automatic test_load_wait();
    int rd_count;
    rd_count = 0;
    mem_rdata = 16'hC400; mem_ready = 1'b1; alu_cout = 1'b1; alu_addr = 16'h1234;
    tick();
    mem_ready = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      tick();
      if (mem_rd === 1'b1 && mem_addr === 16'h1234) rd_count++;
      mem_rdata = 16'hBEEF;
      mem_ready = (c == 6) ? 1'b1 : 1'b0;
    end
    tick();
    n_checks++;
    if (rd_count !== 3) begin
      n_fail++; $display("FAIL load_rd_hold: got %0d cycles expected 3", rd_count);
    end
    n_checks++;
    if (reg_we !== 1'b1 || wb_sel !== 1'b1 || reg_wsel !== 2'b10 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL load_wb: we=%b wbsel=%b wsel=%b rd=%b expected 1 1 10 0", reg_we, wb_sel, reg_wsel, mem_rd);
    end
    n_checks++;
    if (ld_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL load_data: got %h expected beef", ld_data);
    end
    mem_ready = 1'b0;
    tick();
    n_checks++;
    if (carry !== 1'b0 || mem_addr !== 16'h0003 || mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL load_next_fetch: carry=%b addr=%h rd=%b expected 0 0003 1", carry, mem_addr, mem_rd);
    end
  endtask

  // sti: MEM in cycle 4 (ready at once), WB in cycle 5 without REG_WE.
  task automatic test_store();
    mem_rdata = 16'hC800; mem_ready = 1'b1; alu_cout = 1'b1; alu_addr = 16'h0055;
    tick(); tick();
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0055) begin
      n_fail++; $display("FAIL store_mem: wr=%b rd=%b addr=%h expected 1 0 0055", mem_wr, mem_rd, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    n_checks++;
    if (reg_we !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL store_wb: we=%b wr=%b expected 0 0", reg_we, mem_wr);
    end
    tick();
    n_checks++;
    if (carry !== 1'b0 || mem_addr !== 16'h0004 || mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL store_next_fetch: carry=%b addr=%h rd=%b expected 0 0004 1", carry, mem_addr, mem_rd);
    end
  endtask

  // NOP from 0xFFFF: FETCH, DECODE, WB, then FETCH at 0x0000.
  task automatic test_pc_wrap();
    w_n_reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (w_mem_rd !== 1'b1 || w_mem_addr !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_first_fetch: rd=%b addr=%h expected 1 ffff", w_mem_rd, w_mem_addr);
    end
    w_mem_rdata = 16'h0000; w_mem_ready = 1'b1;
    tick(); tick();
    w_mem_ready = 1'b0;
    n_checks++;
    if (w_reg_we !== 1'b0 || w_mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL wrap_nop_wb: we=%b rd=%b expected 0 0", w_reg_we, w_mem_rd);
    end
    tick();
    n_checks++;
    if (w_mem_rd !== 1'b1 || w_mem_addr !== 16'h0000 || w_halted !== 1'b0) begin
      n_fail++; $display("FAIL wrap_next_fetch: rd=%b addr=%h halted=%b expected 1 0000 0", w_mem_rd, w_mem_addr, w_halted);
    end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    mem_rdata = 16'hF800; mem_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_enter: halted=%b expected 1", halted);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b1 || mem_addr !== 16'h0004) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL halt_hold: %0d bad cycles expected 0 (rd=%b addr=%h)", bad, mem_rd, mem_addr);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    n_reset = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
    alu_addr = 16'h0000; alu_cout = 1'b0;
    w_n_reset = 1'b0; w_mem_ready = 1'b0; w_mem_rdata = 16'h0000;
    test_reset();
    test_alu();
    test_mul();
    test_load_wait();
    test_store();
    test_pc_wrap();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
